program_loader: RTL and testbench

Boot-time writer for the 32x32-bit instruction memory that the fetch path reads. It accepts a byte stream over a valid/ready handshake and assembles every four bytes into one 32-bit instruction word. It writes the words into memory addresses 0..31 in order through the memory's write port (address, data, write strobe). For the whole load it holds the processor's program counter in reset, so fetch restarts at address 0 with the new program.

---
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time instruction memory loader: packs a valid/ready byte stream into 32-bit
// words, writes them to addresses 0..DEPTH-1 and holds the CPU in reset meanwhile.
module program_loader #(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_write,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              error_q, error_d;
    logic              xfer;
    logic [31:0]       merged;

    // Place one byte into its lane; the first byte of a word is lane 3 in big-endian mode.
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
        logic [31:0] r;
        logic [1:0]  lane;
        r    = word;
        lane = BIG_ENDIAN ? ~idx : idx;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    assign byte_ready = (state_q == COLLECT);
    assign mem_write  = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign cpu_hold   = (state_q != IDLE);
    assign done       = (state_q == FINISH);
    assign error      = error_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;

    assign xfer   = byte_valid && byte_ready;
    assign merged = merge_byte(word_q, byte_idx_q, byte_data);

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_addr_d = word_addr_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        error_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    byte_idx_d  = '0;
                    word_addr_d = '0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (xfer) begin
                    word_d     = merged;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Write-port registers change only when a complete word is ready.
                    if (byte_idx_q == 2'd3) begin
                        mem_addr_d = word_addr_q;
                        mem_data_d = merged;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (word_addr_q == LAST_ADDR) begin
                    state_d = FINISH;
                end else begin
                    word_addr_d = word_addr_q + 1'b1;
                    state_d     = COLLECT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            word_addr_q <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_addr_q <= word_addr_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: big- and little-endian instances share stimulus.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, abort, byte_valid;
    logic [7:0]  byte_data;
    logic        sel;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        be_ready, be_wr, be_hold, be_busy, be_done, be_err;
    logic [4:0]  be_addr;
    logic [31:0] be_data;
    logic        le_ready, le_wr, le_hold, le_busy, le_done, le_err;
    logic [4:0]  le_addr;
    logic [31:0] le_data;

    logic        ready_s, wr_s, hold_s, busy_s, done_s, err_s;
    logic [4:0]  addr_s;
    logic [31:0] data_s;

    logic [36:0] sb_q[$];
    int          wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          done_cyc = 0, fall_cyc = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] w0 = '0, w31 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    program_loader #(.DEPTH(32), .ADDR_W(5), .BIG_ENDIAN(1'b1)) u_be (
        .CLK(clk), .RST(rst), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(be_ready),
        .mem_addr(be_addr), .mem_data(be_data), .mem_write(be_wr),
        .cpu_hold(be_hold), .busy(be_busy), .done(be_done), .error(be_err)
    );

    program_loader #(.DEPTH(32), .ADDR_W(5), .BIG_ENDIAN(1'b0)) u_le (
        .CLK(clk), .RST(rst), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(le_ready),
        .mem_addr(le_addr), .mem_data(le_data), .mem_write(le_wr),
        .cpu_hold(le_hold), .busy(le_busy), .done(le_done), .error(le_err)
    );

    always_comb begin
        ready_s = sel ? le_ready : be_ready;
        wr_s    = sel ? le_wr    : be_wr;
        hold_s  = sel ? le_hold  : be_hold;
        busy_s  = sel ? le_busy  : be_busy;
        done_s  = sel ? le_done  : be_done;
        err_s   = sel ? le_err   : be_err;
        addr_s  = sel ? le_addr  : be_addr;
        data_s  = sel ? le_data  : be_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [36:0] e;
        if (wr_s) begin
            wr_cnt++;
            check("ready_in_write", ready_s, 1'b0);
            if (sb_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", addr_s, e[36:32]);
                check("wr_data", data_s, e[31:0]);
            end
            if (addr_s == 5'd0)  w0  = data_s;
            if (addr_s == 5'd31) w31 = data_s;
        end
        if (done_s) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_s) err_cnt++;
        if (hold_prev && !hold_s) fall_cyc = cyc;
        hold_prev = hold_s;
    end

    // Drives nbytes bytes starting at 0; expected words are queued as their last byte is offered.
    task automatic stream(input int nbytes, input bit toggle, input bit be);
        int i = 0;
        int k = 0;
        int n;
        logic [31:0] w;
        while (i < nbytes && k < 4000) begin
            byte_valid = toggle ? ~byte_valid : 1'b1;
            byte_data  = 8'(i);
            if (byte_valid && ready_s) begin
                if (i % 4 == 3) begin
                    n = i / 4;
                    w = be ? {8'(4*n), 8'(4*n+1), 8'(4*n+2), 8'(4*n+3)}
                           : {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
                    sb_q.push_back({5'(n), w});
                end
                i++;
            end
            @(negedge clk);
            k++;
        end
        byte_valid = 1'b0;
        check("stream_bytes_taken", i, nbytes);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done_s && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_s, 1'b1);
    endtask

    task automatic begin_load(input bit keep_start);
        start = 1'b1;
        @(negedge clk);
        start = keep_start;
    endtask

    task automatic check_zero_outs(input string tag);
        check(tag, {ready_s, wr_s, hold_s, busy_s, done_s, err_s, addr_s, data_s}, 64'd0);
    endtask

    initial begin
        int s, base, dbase, ebase;
        rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outs("reset_outs");
        rst = 1'b0;

        base = wr_cnt;
        repeat (10) begin
            @(negedge clk);
            check("idle_ready", ready_s, 1'b0);
        end
        check("idle_no_write", wr_cnt - base, 0);
        check("idle_busy", busy_s, 1'b0);

        // Big-endian full load with byte_valid held high
        base = wr_cnt; dbase = done_cnt;
        s = cyc + 1;
        begin_load(1'b0);
        check("rise_busy_hold_ready", {busy_s, hold_s, ready_s}, 3'b111);
        stream(128, 1'b0, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        check("be_writes", wr_cnt - base, 32);
        check("be_done_once", done_cnt - dbase, 1);
        check("be_done_cycle", done_cyc, s + 160);
        check("be_hold_fall_cycle", fall_cyc, s + 161);
        check("be_word0", w0, 32'h00010203);
        check("be_word31", w31, 32'h7C7D7E7F);
        check("be_sb_empty", sb_q.size(), 0);

        // Little-endian load with byte_valid toggling
        sel = 1'b1;
        base = wr_cnt;
        begin_load(1'b0);
        stream(128, 1'b1, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        check("le_writes", wr_cnt - base, 32);
        check("le_word0", w0, 32'h03020100);
        check("le_word31", w31, 32'h7F7E7D7C);
        check("le_sb_empty", sb_q.size(), 0);

        // Abort after two words plus two bytes
        sel = 1'b0;
        base = wr_cnt; dbase = done_cnt; ebase = err_cnt;
        begin_load(1'b0);
        stream(10, 1'b0, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_error_pulse", err_s, 1'b1);
        check("abort_hold_low", hold_s, 1'b0);
        check("abort_idle", busy_s, 1'b0);
        repeat (5) @(negedge clk);
        check("abort_writes", wr_cnt - base, 2);
        check("abort_err_once", err_cnt - ebase, 1);
        check("abort_no_done", done_cnt - dbase, 0);
        check("abort_sb_empty", sb_q.size(), 0);
        base = wr_cnt;
        begin_load(1'b0);
        stream(128, 1'b0, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        check("reload_writes", wr_cnt - base, 32);
        check("reload_sb_empty", sb_q.size(), 0);

        // start held high through a load and past done
        base = wr_cnt; dbase = done_cnt; ebase = err_cnt;
        begin_load(1'b1);
        stream(128, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        check("held_back_to_idle", busy_s, 1'b0);
        @(negedge clk);
        check("held_restart_after_idle", {busy_s, ready_s}, 2'b11);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("held_abort_error", err_s, 1'b1);
        check("held_writes", wr_cnt - base, 32);
        check("held_done_once", done_cnt - dbase, 1);
        check("held_sb_empty", sb_q.size(), 0);

        // Asynchronous reset during a WRITE cycle
        base = wr_cnt;
        begin_load(1'b0);
        stream(4, 1'b0, 1'b1);
        check("rstw_in_write", wr_s, 1'b1);
        #1 rst = 1'b1;
        #1 check_zero_outs("rst_async_outs");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstw_sb_empty", sb_q.size(), 0);
        begin_load(1'b0);
        stream(128, 1'b0, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        check("rstw_writes", wr_cnt - base, 33);
        check("rstw_word0", w0, 32'h00010203);
        check("rstw_final_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
